// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ctrl_pkg
//  Description : Shared definitions for the multicycle RISC-V controller and
//                its ALU control decoder. Holds opcode constants, ALUOp class
//                codes, the FSM state encoding and the control decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    // Major opcodes (ir[6:0]) understood by the controller
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_ialu   = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    // ALU class handed to the ALU control decoder
    localparam logic [1:0] c_aluop_add    = 2'b00;
    localparam logic [1:0] c_aluop_branch = 2'b01;
    localparam logic [1:0] c_aluop_rtype  = 2'b10;
    localparam logic [1:0] c_aluop_itype  = 2'b11;

    // ALU operand B selects
    localparam logic [1:0] c_srcb_rs2 = 2'b00;
    localparam logic [1:0] c_srcb_imm = 2'b01;

    // Controller states; codes 5 and 6 are unused and recover to FETCH
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    // Bundle of datapath control strobes and selects
    typedef struct packed {
        logic [1:0] aluop;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
    } ctrl_t;

    // Instruction class flags produced by opcode_class
    typedef struct packed {
        logic is_r;
        logic is_i;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic legal;
    } opclass_t;

    // Control outputs as a function of state and captured instruction class.
    // The fetch-completion strobes (IR load, PC+4) are qualified by the
    // memory handshake so a stalled fetch never advances the PC.
    function automatic ctrl_t ctrl_decode(input state_t   st,
                                          input opclass_t cls,
                                          input logic     mem_ready);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b0;
                c.ir_write = mem_ready;
                c.pc_write = mem_ready;
            end
            S_EXEC: begin
                if (cls.legal) begin
                    c.alu_src_a = 1'b1;
                    if (cls.is_r) begin
                        c.aluop     = c_aluop_rtype;
                        c.alu_src_b = c_srcb_rs2;
                    end else if (cls.is_i) begin
                        c.aluop     = c_aluop_itype;
                        c.alu_src_b = c_srcb_imm;
                    end else if (cls.is_load || cls.is_store) begin
                        c.aluop     = c_aluop_add;
                        c.alu_src_b = c_srcb_imm;
                    end else if (cls.is_branch) begin
                        c.aluop         = c_aluop_branch;
                        c.alu_src_b     = c_srcb_rs2;
                        c.pc_write_cond = 1'b1;
                    end
                end
            end
            S_MEM: begin
                c.iord      = 1'b1;
                c.mem_read  = cls.is_load;
                c.mem_write = cls.is_store;
            end
            S_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = cls.is_load;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Memory handshake and datapath control bundle between the
//                multicycle controller (master) and the datapath (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;

    // Memory side
    logic [31:0] instr_in;
    logic        mem_ready;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;

    // Datapath control
    logic [1:0]  ALUOp;
    logic [3:0]  FuncCode;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemtoReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;

    modport master (
        input  instr_in, mem_ready,
        output MemRead, MemWrite, IorD,
        output ALUOp, FuncCode, PCWrite, PCWriteCond, IRWrite,
        output RegWrite, MemtoReg, ALUSrcA, ALUSrcB
    );

    modport slave (
        output instr_in, mem_ready,
        input  MemRead, MemWrite, IorD,
        input  ALUOp, FuncCode, PCWrite, PCWriteCond, IRWrite,
        input  RegWrite, MemtoReg, ALUSrcA, ALUSrcB
    );

endinterface
`default_nettype wire

// File: rtl/opcode_class.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_class
//  Description : Combinational classifier of the major opcode field into
//                instruction class flags plus a legality indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module opcode_class
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_r,
    output logic       is_i,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       legal
);

    // One-hot class match; anything unmatched is illegal
    always_comb begin
        is_r      = (opcode == c_op_rtype);
        is_i      = (opcode == c_op_ialu);
        is_load   = (opcode == c_op_load);
        is_store  = (opcode == c_op_store);
        is_branch = (opcode == c_op_branch);
        legal     = is_r | is_i | is_load | is_store | is_branch;
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle RISC-V main controller. Sequences FETCH, DECODE,
//                EXEC, MEM and WB, traps on unknown opcodes and counts
//                retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus,
    output logic [2:0]           state_o,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [INSTRET_W-1:0] c_one = INSTRET_W'(1);

    state_t                r_state;
    logic [31:0]           r_ir;
    logic                  r_illegal;
    logic [INSTRET_W-1:0]  r_instret;

    logic                  w_is_r;
    logic                  w_is_i;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_is_branch;
    logic                  w_legal;
    opclass_t              w_cls;
    ctrl_t                 w_ctrl;

    // Only the opcode and function bits of the IR steer the controller;
    // the remaining fields belong to the datapath.
    logic                  w_unused_ir;
    assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};

    opcode_class u_opcode_class (
        .opcode    (r_ir[6:0]),
        .is_r      (w_is_r),
        .is_i      (w_is_i),
        .is_load   (w_is_load),
        .is_store  (w_is_store),
        .is_branch (w_is_branch),
        .legal     (w_legal)
    );

    assign w_cls = {w_is_r, w_is_i, w_is_load, w_is_store, w_is_branch, w_legal};

    // Sequencer: state, instruction register, sticky trap flag and retire count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_ir    <= bus.instr_in;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_is_branch) begin
                        r_state   <= S_FETCH;
                        r_instret <= r_instret + c_one;
                    end else if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (w_is_load) begin
                            r_state <= S_WB;
                        end else begin
                            r_state   <= S_FETCH;
                            r_instret <= r_instret + c_one;
                        end
                    end
                end
                S_WB: begin
                    r_state   <= S_FETCH;
                    r_instret <= r_instret + c_one;
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Control decode from the state register; reset forces every strobe low
    // immediately so the first cycle after release already presents FETCH.
    always_comb begin
        w_ctrl = '0;
        if (!reset) begin
            w_ctrl = ctrl_decode(r_state, w_cls, bus.mem_ready);
        end
    end

    assign bus.ALUOp       = w_ctrl.aluop;
    assign bus.PCWrite     = w_ctrl.pc_write;
    assign bus.PCWriteCond = w_ctrl.pc_write_cond;
    assign bus.IRWrite     = w_ctrl.ir_write;
    assign bus.MemRead     = w_ctrl.mem_read;
    assign bus.MemWrite    = w_ctrl.mem_write;
    assign bus.IorD        = w_ctrl.iord;
    assign bus.RegWrite    = w_ctrl.reg_write;
    assign bus.MemtoReg    = w_ctrl.mem_to_reg;
    assign bus.ALUSrcA     = w_ctrl.alu_src_a;
    assign bus.ALUSrcB     = w_ctrl.alu_src_b;
    assign bus.FuncCode    = {r_ir[30], r_ir[14:12]};

    assign state_o = r_state;
    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. A 32-bit and a
//                4-bit retire-counter instance share one stimulus stream;
//                per-cycle expectations are queued and compared on negedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LD  = 2;
    localparam int K_ST  = 3;
    localparam int K_BR  = 4;
    localparam int K_ILL = 5;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    typedef struct packed {
        logic [2:0]  st;
        logic [12:0] ctl;
        logic        ill;
        logic        chkf;
        logic [3:0]  func;
        logic [31:0] instret;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_in = '0;
    logic        mem_ready = 1'b0;

    logic [2:0]  st32, st4;
    logic        ill32, ill4;
    logic [31:0] ret32;
    logic [3:0]  ret4;

    exp_t        q_exp[$];
    string       q_tag[$];
    exp_t        e_cur;
    string       t_cur;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] tb_ir = '0;
    logic [31:0] exp_instret = '0;

    logic [12:0] c_zero, c_fwait, c_fgo, c_exr, c_exi, c_exls, c_exbr;
    logic [12:0] c_mld, c_mst, c_wbr, c_wbl;

    always #5 clk = ~clk;

    multicycle_control_if bus32 ();
    multicycle_control_if bus4 ();

    assign bus32.instr_in  = instr_in;
    assign bus32.mem_ready = mem_ready;
    assign bus4.instr_in   = instr_in;
    assign bus4.mem_ready  = mem_ready;

    multicycle_control #(.INSTRET_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus32),
        .state_o (st32),
        .illegal (ill32),
        .instret (ret32)
    );

    multicycle_control #(.INSTRET_W(4)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus4),
        .state_o (st4),
        .illegal (ill4),
        .instret (ret4)
    );

    function automatic logic [12:0] mk(input logic [1:0] aop, input logic pcw,
                                       input logic pcwc, input logic irw,
                                       input logic mr, input logic mw,
                                       input logic iord, input logic rw,
                                       input logic m2r, input logic sa,
                                       input logic [1:0] sb);
        return {aop, pcw, pcwc, irw, mr, mw, iord, rw, m2r, sa, sb};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: compare both instances against the queued cycle
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            e_cur = q_exp.pop_front();
            t_cur = q_tag.pop_front();
            check_val({t_cur, "/state"}, 32'(st32), 32'(e_cur.st));
            check_val({t_cur, "/ctl"}, 32'({bus32.ALUOp, bus32.PCWrite, bus32.PCWriteCond,
                      bus32.IRWrite, bus32.MemRead, bus32.MemWrite, bus32.IorD,
                      bus32.RegWrite, bus32.MemtoReg, bus32.ALUSrcA, bus32.ALUSrcB}),
                      32'(e_cur.ctl));
            check_val({t_cur, "/illegal"}, 32'(ill32), 32'(e_cur.ill));
            check_val({t_cur, "/instret"}, ret32, e_cur.instret);
            check_val({t_cur, "/state4"}, 32'(st4), 32'(e_cur.st));
            check_val({t_cur, "/ctl4"}, 32'({bus4.ALUOp, bus4.PCWrite, bus4.PCWriteCond,
                      bus4.IRWrite, bus4.MemRead, bus4.MemWrite, bus4.IorD,
                      bus4.RegWrite, bus4.MemtoReg, bus4.ALUSrcA, bus4.ALUSrcB}),
                      32'(e_cur.ctl));
            check_val({t_cur, "/instret4"}, 32'(ret4), 32'(e_cur.instret[3:0]));
            if (e_cur.chkf) begin
                check_val({t_cur, "/func"}, 32'(bus32.FuncCode), 32'(e_cur.func));
            end
        end
    end

    // One clock of stimulus plus the expectations for that same cycle
    task automatic step(input logic rst_v, input logic [31:0] ins, input logic rdy,
                        input logic [2:0] st, input logic [12:0] ctl, input logic ill,
                        input logic chkf, input logic ret, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst_v;
        instr_in  = ins;
        mem_ready = rdy;
        if (rst_v) begin
            exp_instret = '0;
            tb_ir       = '0;
        end
        e.st      = st;
        e.ctl     = ctl;
        e.ill     = ill;
        e.chkf    = chkf;
        e.func    = {tb_ir[30], tb_ir[14:12]};
        e.instret = exp_instret;
        q_exp.push_back(e);
        q_tag.push_back(tag);
        if (!rst_v && st == ST_FETCH && rdy) tb_ir = ins;
        if (ret) exp_instret = exp_instret + 32'd1;
    endtask

    // Full instruction with optional fetch and memory wait states
    task automatic run(input logic [31:0] ins, input int cls, input int fw, input int mw);
        for (int i = 0; i < fw; i++) step(1'b0, ins, 1'b0, ST_FETCH, c_fwait, 1'b0, 1'b0, 1'b0, "fetch_wait");
        step(1'b0, ins, 1'b1, ST_FETCH, c_fgo, 1'b0, 1'b0, 1'b0, "fetch");
        step(1'b0, ins, 1'($urandom_range(0, 1)), ST_DECODE, c_zero, 1'b0, 1'b0, 1'b0, "decode");
        if (cls == K_ILL) begin
            for (int i = 0; i < 10; i++)
                step(1'b0, ins, 1'($urandom_range(0, 1)), ST_TRAP, c_zero, 1'b1, 1'b0, 1'b0, "trap");
            return;
        end
        case (cls)
            K_R: begin
                step(1'b0, ins, 1'($urandom_range(0, 1)), ST_EXEC, c_exr, 1'b0, 1'b1, 1'b0, "exec_r");
                step(1'b0, ins, 1'($urandom_range(0, 1)), ST_WB, c_wbr, 1'b0, 1'b0, 1'b1, "wb_r");
            end
            K_I: begin
                step(1'b0, ins, 1'($urandom_range(0, 1)), ST_EXEC, c_exi, 1'b0, 1'b1, 1'b0, "exec_i");
                step(1'b0, ins, 1'($urandom_range(0, 1)), ST_WB, c_wbr, 1'b0, 1'b0, 1'b1, "wb_i");
            end
            K_LD: begin
                step(1'b0, ins, 1'($urandom_range(0, 1)), ST_EXEC, c_exls, 1'b0, 1'b1, 1'b0, "exec_ld");
                for (int i = 0; i < mw; i++) step(1'b0, ins, 1'b0, ST_MEM, c_mld, 1'b0, 1'b0, 1'b0, "mem_ld_wait");
                step(1'b0, ins, 1'b1, ST_MEM, c_mld, 1'b0, 1'b0, 1'b0, "mem_ld");
                step(1'b0, ins, 1'($urandom_range(0, 1)), ST_WB, c_wbl, 1'b0, 1'b0, 1'b1, "wb_ld");
            end
            K_ST: begin
                step(1'b0, ins, 1'($urandom_range(0, 1)), ST_EXEC, c_exls, 1'b0, 1'b1, 1'b0, "exec_st");
                for (int i = 0; i < mw; i++) step(1'b0, ins, 1'b0, ST_MEM, c_mst, 1'b0, 1'b0, 1'b0, "mem_st_wait");
                step(1'b0, ins, 1'b1, ST_MEM, c_mst, 1'b0, 1'b0, 1'b1, "mem_st");
            end
            default: begin
                step(1'b0, ins, 1'($urandom_range(0, 1)), ST_EXEC, c_exbr, 1'b0, 1'b1, 1'b1, "exec_br");
            end
        endcase
    endtask

    initial begin
        c_zero  = '0;
        c_fwait = mk(2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        c_fgo   = mk(2'b00, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00);
        c_exr   = mk(2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00);
        c_exi   = mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01);
        c_exls  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01);
        c_exbr  = mk(2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00);
        c_mld   = mk(2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00);
        c_mst   = mk(2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00);
        c_wbr   = mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00);
        c_wbl   = mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00);

        // Reset state
        step(1'b1, 32'h0, 1'b1, ST_FETCH, c_zero, 1'b0, 1'b0, 1'b0, "reset");
        step(1'b1, 32'h0, 1'b1, ST_FETCH, c_zero, 1'b0, 1'b0, 1'b0, "reset");

        // add, load with waits, beq, slli, store with waits
        run(32'h002081B3, K_R,  0, 0);
        run(32'h0000A183, K_LD, 1, 3);
        run(32'h00208463, K_BR, 0, 0);
        run(32'h00109093, K_I,  0, 0);
        run(32'h0020A023, K_ST, 2, 1);

        // Store aborted by reset while its memory access is pending
        step(1'b0, 32'h0020A023, 1'b1, ST_FETCH, c_fgo, 1'b0, 1'b0, 1'b0, "ab_fetch");
        step(1'b0, 32'h0020A023, 1'b0, ST_DECODE, c_zero, 1'b0, 1'b0, 1'b0, "ab_decode");
        step(1'b0, 32'h0020A023, 1'b0, ST_EXEC, c_exls, 1'b0, 1'b1, 1'b0, "ab_exec");
        step(1'b0, 32'h0020A023, 1'b0, ST_MEM, c_mst, 1'b0, 1'b0, 1'b0, "ab_mem");
        step(1'b1, 32'h0020A023, 1'b1, ST_FETCH, c_zero, 1'b0, 1'b0, 1'b0, "ab_reset");
        step(1'b0, 32'h0020A023, 1'b0, ST_FETCH, c_fwait, 1'b0, 1'b0, 1'b0, "ab_post");
        step(1'b0, 32'h0020A023, 1'b0, ST_FETCH, c_fwait, 1'b0, 1'b0, 1'b0, "ab_post");

        // Sixteen retires wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) run(32'h00208463, K_BR, 0, 0);
        run(32'h002081B3, K_R, 0, 0);

        // Illegal opcode traps, then reset clears the sticky flag
        run(32'hFFFFFFFF, K_ILL, 0, 0);
        step(1'b1, 32'h0, 1'b0, ST_FETCH, c_zero, 1'b0, 1'b0, 1'b0, "trap_reset");
        step(1'b0, 32'h0, 1'b0, ST_FETCH, c_fwait, 1'b0, 1'b0, 1'b0, "trap_post");
        run(32'h00109093, K_I, 0, 0);

        @(negedge clk);
        #1;
        check_val("sb_drain", 32'(q_exp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
